washer_btn_conditioner: RTL and testbench

//   Input front-end for the Washer: turns raw, bouncing panel buttons into the

---
 rtl/washer_pkg.sv | 20 ++
 rtl/btn_debounce_ch.sv | 143 ++++++++++++++
 rtl/washer_btn_conditioner.sv | 53 +++++
 tb/tb_washer_btn_conditioner.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// Shared definitions for the washer panel button front-end.
// Holds the per-channel debounce state encoding and the button bit positions.
// No ports; imported by the channel and top-level modules.
package washer_pkg;

  // Per-channel debounce FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } btn_state_e;

  // Bit positions of the panel buttons inside the raw/clean button vectors.
  localparam int unsigned BTN_RUN   = 0;
  localparam int unsigned BTN_WATER = 1;
  localparam int unsigned BTN_OPEN  = 2;
  localparam int unsigned BTN_CLICK = 3;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM, press/release/long pulses.
// Latency: raw edge to press/release pulse is 2 + DEB_CYCLES cycles; no backpressure.
// Ports: clk_i, rst_ni (async active-low), raw_i -> level_o, press_o, press_nxt_o,
//        release_o, long_o (press_nxt_o is the value press_o takes on the next edge).
module btn_debounce_ch
  import washer_pkg::*;
#(
  parameter int DEB_CYCLES  = 16,
  parameter int LONG_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic press_nxt_o,
  output logic release_o,
  output logic long_o
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DEB_ONE  = DW'(1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYCLES);

  logic          sync1_q, sync2_q;
  btn_state_e    state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          long_done_q, long_done_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    // The hold timer keeps running while a release is being debounced, so a
    // short glitch neither restarts nor delays the long-press pulse.
    if ((state_q == HELD) || (state_q == DEB_RELEASE)) begin
      if (hold_cnt_q != HOLD_SAT) begin
        hold_cnt_d = hold_cnt_q + HOLD_ONE;
      end
      if ((hold_cnt_q == HOLD_LAST) && !long_done_q) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end
    end

    // The IDLE/HELD sample counts as the first stable sample, so the edge is
    // accepted when the counter already holds DEB_CYCLES-1.
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d   = DEB_PRESS;
          deb_cnt_d = DEB_ONE;
        end
      end
      DEB_PRESS: begin
        if (!sync2_q) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = HELD;
          deb_cnt_d   = '0;
          press_d     = 1'b1;
          level_d     = 1'b1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d   = DEB_RELEASE;
          deb_cnt_d = DEB_ONE;
        end
      end
      DEB_RELEASE: begin
        if (sync2_q) begin
          // Glitch rejected: back to HELD with hold timer and long flag intact.
          state_d   = HELD;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = IDLE;
          deb_cnt_d   = '0;
          release_d   = 1'b1;
          level_d     = 1'b0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q     <= raw_i;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign level_o     = level_q;
  assign press_o     = press_q;
  assign press_nxt_o = press_d;
  assign release_o   = release_q;
  assign long_o      = long_q;

endmodule

// File: rtl/washer_btn_conditioner.sv
// Washer panel input front-end: N_BTN independent debounce channels plus key-beep request.
// Latency: raw edge to press/release pulse is 2 + DEB_CYCLES cycles; no backpressure.
// Ports: clk, in_resetBtn (async active-low), in_rawBtn -> out_level, out_press,
//        out_release, out_long, out_anyPress (OR of press pulses, same cycle as out_press).
module washer_btn_conditioner
  import washer_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int DEB_CYCLES  = 16,
  parameter int LONG_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             in_resetBtn,
  input  logic [N_BTN-1:0] in_rawBtn,
  output logic [N_BTN-1:0] out_level,
  output logic [N_BTN-1:0] out_press,
  output logic [N_BTN-1:0] out_release,
  output logic [N_BTN-1:0] out_long,
  output logic             out_anyPress
);

  logic [N_BTN-1:0] press_nxt;
  logic             any_press_q;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk_i      (clk),
      .rst_ni     (in_resetBtn),
      .raw_i      (in_rawBtn[g]),
      .level_o    (out_level[g]),
      .press_o    (out_press[g]),
      .press_nxt_o(press_nxt[g]),
      .release_o  (out_release[g]),
      .long_o     (out_long[g])
    );
  end

  // Registered from the channels' next-state press values so the beep request
  // lines up exactly with out_press while still coming straight from a flop.
  always_ff @(posedge clk or negedge in_resetBtn) begin
    if (!in_resetBtn) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_nxt;
    end
  end

  assign out_anyPress = any_press_q;

endmodule

// File: tb/tb_washer_btn_conditioner.sv
module tb_washer_btn_conditioner;
  import washer_pkg::*;

  localparam int N    = 4;
  localparam int DEB  = 16;
  localparam int LONG = 1000;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] raw;
  logic [N-1:0] out_level, out_press, out_release, out_long;
  logic         out_anyPress;

  int cyc     = 0;
  int n_pass  = 0;
  int n_checks = 0;

  washer_btn_conditioner #(
    .N_BTN(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG)
  ) dut (
    .clk         (clk),
    .in_resetBtn (rst_n),
    .in_rawBtn   (raw),
    .out_level   (out_level),
    .out_press   (out_press),
    .out_release (out_release),
    .out_long    (out_long),
    .out_anyPress(out_anyPress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the sampled button value is the raw level two edges ago;
  // a new level is accepted once DEB consecutive samples disagree with the
  // current level. Long fires LONG edges after the press edge if still held.
  logic [N-1:0] m_d1 = '0, m_d2 = '0, m_lvl = '0, m_done = '0;
  logic [N-1:0] m_press = '0, m_rel = '0, m_long = '0;
  int m_run [N];
  int m_since [N];

  task automatic model_step();
    logic [N-1:0] smp;
    smp  = m_d2;
    m_d2 = m_d1;
    m_d1 = raw;
    m_press = '0; m_rel = '0; m_long = '0;
    for (int i = 0; i < N; i++) begin
      if (m_lvl[i] && !m_done[i] && (m_since[i] == LONG - 1)) begin
        m_long[i] = 1'b1;
        m_done[i] = 1'b1;
      end
      if (m_lvl[i]) m_since[i]++;
      if (smp[i] != m_lvl[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == DEB) begin
        m_run[i] = 0;
        m_lvl[i] = smp[i];
        if (smp[i]) begin
          m_press[i] = 1'b1;
          m_since[i] = 0;
          m_done[i]  = 1'b0;
        end else begin
          m_rel[i] = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_done = '0;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i]   = 0;
        m_since[i] = 0;
      end
    end else begin
      model_step();
    end
  end

  logic [4*N:0] obs_vec, exp_vec;
  assign obs_vec = {out_level, out_press, out_release, out_long, out_anyPress};
  assign exp_vec = {m_lvl, m_press, m_rel, m_long, |m_press};

  task automatic test_reset();
    rst_n = 1'b0;
    raw   = '0;
    repeat (50) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== '0) $display("FAIL reset_zero cyc=%0d got=%h exp=0", cyc, obs_vec);
      else n_pass++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
    end
  endtask

  task automatic test_click();
    int t0, t1, p_at, a_at, p_cnt, r_at;
    p_at = -1; a_at = -1; p_cnt = 0; r_at = -1;
    raw[BTN_CLICK] = 1'b1;
    t0 = cyc;
    repeat (40) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL click cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
      if (out_press[BTN_CLICK]) begin p_at = cyc - t0; p_cnt++; end
      if (out_anyPress) a_at = cyc - t0;
    end
    n_checks++;
    if (p_at !== 18 || p_cnt !== 1) $display("FAIL click_press_at got=%0d (count %0d) exp=18 (count 1)", p_at, p_cnt);
    else n_pass++;
    n_checks++;
    if (a_at !== 18) $display("FAIL click_any_at got=%0d exp=18", a_at);
    else n_pass++;
    n_checks++;
    if (out_level[BTN_CLICK] !== 1'b1) $display("FAIL click_level got=%b exp=1", out_level[BTN_CLICK]);
    else n_pass++;
    raw[BTN_CLICK] = 1'b0;
    t1 = cyc;
    repeat (25) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL click_rel cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
      if (out_release[BTN_CLICK]) r_at = cyc - t1;
    end
    n_checks++;
    if (r_at !== 18) $display("FAIL click_release_at got=%0d exp=18", r_at);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int t0, pulses;
    pulses = 0;
    t0 = cyc;
    repeat (130) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL bounce cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
      pulses += int'(out_press[BTN_RUN]) + int'(out_release[BTN_RUN]);
      if (cyc - t0 < 100) begin
        if ((cyc - t0) % 5 == 0) raw[BTN_RUN] = ~raw[BTN_RUN];
      end else begin
        raw[BTN_RUN] = 1'b0;
      end
    end
    n_checks++;
    if (pulses !== 0) $display("FAIL bounce_pulses got=%0d exp=0", pulses);
    else n_pass++;
  endtask

  task automatic test_long();
    int t0, t1, p_at, l_at, l_cnt, r_at;
    p_at = -1; l_at = -1; l_cnt = 0; r_at = -1;
    raw[BTN_WATER] = 1'b1;
    t0 = cyc;
    repeat (1200) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL long cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
      if (out_press[BTN_WATER]) p_at = cyc - t0;
      if (out_long[BTN_WATER]) begin l_cnt++; l_at = cyc - t0; end
    end
    raw[BTN_WATER] = 1'b0;
    t1 = cyc;
    repeat (25) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL long_rel cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
      if (out_release[BTN_WATER]) r_at = cyc - t1;
    end
    n_checks++;
    if (p_at !== 18) $display("FAIL long_press_at got=%0d exp=18", p_at);
    else n_pass++;
    n_checks++;
    if (l_cnt !== 1 || l_at !== 1018) $display("FAIL long_pulse got=%0d at %0d exp=1 at 1018", l_cnt, l_at);
    else n_pass++;
    n_checks++;
    if (r_at !== 18) $display("FAIL long_release_at got=%0d exp=18", r_at);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int t0, p_cnt, r_cnt, l_cnt, l_at, off;
    p_cnt = 0; r_cnt = 0; l_cnt = 0; l_at = -1;
    raw[BTN_OPEN] = 1'b1;
    t0 = cyc;
    repeat (1200) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL glitch cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
      p_cnt += int'(out_press[BTN_OPEN]);
      r_cnt += int'(out_release[BTN_OPEN]);
      if (out_long[BTN_OPEN]) begin l_cnt++; l_at = cyc - t0; end
      off = cyc - t0;
      if (off == 400) raw[BTN_OPEN] = 1'b0;
      if (off == 408) raw[BTN_OPEN] = 1'b1;
    end
    n_checks++;
    if (p_cnt !== 1 || r_cnt !== 0) $display("FAIL glitch_pulses got=%0d press %0d release exp=1 press 0 release", p_cnt, r_cnt);
    else n_pass++;
    n_checks++;
    if (l_cnt !== 1 || l_at !== 1018) $display("FAIL glitch_long got=%0d at %0d exp=1 at 1018", l_cnt, l_at);
    else n_pass++;
    raw[BTN_OPEN] = 1'b0;
    repeat (25) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL glitch_rel cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int t0, r, off, run_at, clk_at, any_cnt, rel_cnt;
    run_at = -1; clk_at = -1; any_cnt = 0; rel_cnt = 0; r = 0;
    raw[BTN_RUN]   = 1'b1;
    raw[BTN_CLICK] = 1'b1;
    t0 = cyc;
    repeat (45) begin
      @(negedge clk);
      off = cyc - t0;
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL rst_mid cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
      if (!rst_n) begin
        n_checks++;
        if (obs_vec !== '0) $display("FAIL rst_mid_zero cyc=%0d got=%h exp=0", cyc, obs_vec);
        else n_pass++;
      end
      if (out_press[BTN_RUN]) run_at = cyc;
      if (out_press[BTN_CLICK]) clk_at = cyc;
      any_cnt += int'(out_anyPress);
      rel_cnt += int'(|out_release);
      if (off == 10) rst_n = 1'b0;
      if (off == 13) begin rst_n = 1'b1; r = cyc; end
    end
    n_checks++;
    if (run_at - r !== 18 || clk_at - r !== 18)
      $display("FAIL rst_mid_press_at got=%0d/%0d exp=18/18", run_at - r, clk_at - r);
    else n_pass++;
    n_checks++;
    if (any_cnt !== 1 || rel_cnt !== 0) $display("FAIL rst_mid_any got=%0d any %0d rel exp=1 any 0 rel", any_cnt, rel_cnt);
    else n_pass++;
    raw = '0;
    repeat (25) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL rst_mid_rel cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int rem [N];
    int rst_hold;
    rst_hold = 0;
    for (int i = 0; i < N; i++) rem[i] = int'($urandom_range(1, 30));
    repeat (5000) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
      for (int i = 0; i < N; i++) begin
        rem[i]--;
        if (rem[i] <= 0) begin
          raw[i] = ~raw[i];
          if ($urandom_range(0, 59) == 0) rem[i] = int'($urandom_range(990, 1100));
          else if ($urandom_range(0, 2) == 0) rem[i] = int'($urandom_range(1, 16));
          else rem[i] = int'($urandom_range(14, 60));
        end
      end
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        rst_hold = int'($urandom_range(1, 3));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    raw   = '0;
    test_reset();
    test_click();
    test_bounce();
    test_long();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
